// File: rtl/hps_fgpa_led_pwm_output_if.sv
// Avalon-MM slave bus bundle for the LED PWM output port.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : write strobe, active low
//   writedata  : write data (32 bits)
//   readdata   : read data, combinational (read latency 0)
interface hps_fgpa_led_pwm_output_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n,
                    output writedata, input readdata);
    modport slave  (input address, input chipselect, input write_n,
                    input writedata, output readdata);
endinterface

// File: rtl/hps_fgpa_led_pwm_output.sv
// Avalon-MM LED output port: DATA with atomic set/clear/toggle, per-channel
// blink with programmable half-period, and global PWM brightness.
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   bus      : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port : registered LED drive, WIDTH bits
module hps_fgpa_led_pwm_output #(
    parameter int unsigned       WIDTH          = 4,
    parameter int unsigned       PERIOD_W       = 24,
    parameter int unsigned       DEFAULT_PERIOD = 12500000,
    parameter int unsigned       PWM_W          = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    hps_fgpa_led_pwm_output_if.slave    bus,
    output logic [WIDTH-1:0]            out_port
);

    localparam int unsigned DUTY_W = PWM_W + 1;
    localparam logic [DUTY_W-1:0] DUTY_FULL = {1'b1, {PWM_W{1'b0}}};

    logic [WIDTH-1:0]    data_q,    data_d;
    logic [WIDTH-1:0]    mode_q,    mode_d;
    logic [PERIOD_W-1:0] period_q,  period_d;
    logic [DUTY_W-1:0]   duty_q,    duty_d;
    logic [PERIOD_W-1:0] cnt_q,     cnt_d;
    logic                phase_q,   phase_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]    out_q,     out_d;

    logic             wr_c;
    logic             pwm_on_c;
    logic [WIDTH-1:0] wd_c;
    logic             unused_wd_c;

    assign wr_c        = bus.chipselect & ~bus.write_n;
    assign wd_c        = bus.writedata[WIDTH-1:0];
    assign unused_wd_c = ^bus.writedata;
    assign pwm_on_c    = {1'b0, pwm_cnt_q} < duty_q;
    assign out_port    = out_q;

    // Register writes, blink/PWM counters and LED output next-state.
    always_comb begin
        data_d    = data_q;
        mode_d    = mode_q;
        period_d  = period_q;
        duty_d    = duty_q;
        cnt_d     = cnt_q + PERIOD_W'(1);
        phase_d   = phase_q;
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

        if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end

        if (wr_c) begin
            case (bus.address)
                3'd0: data_d = wd_c;
                3'd1: mode_d = wd_c;
                3'd2: begin
                    // A PERIOD write restarts the blink, overriding any wrap.
                    period_d = bus.writedata[PERIOD_W-1:0];
                    cnt_d    = '0;
                    phase_d  = 1'b1;
                end
                3'd3: duty_d = bus.writedata[DUTY_W-1:0];
                3'd4: data_d = data_q | wd_c;
                3'd5: data_d = data_q & ~wd_c;
                3'd6: data_d = data_q ^ wd_c;
                default: ;
            endcase
        end

        // Static channels ignore phase; everything is gated by PWM.
        out_d = data_q & (~mode_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on_c}};
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= RESET_VALUE;
            mode_q    <= '0;
            period_q  <= PERIOD_W'(DEFAULT_PERIOD);
            duty_q    <= DUTY_FULL;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
            pwm_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            out_q     <= out_d;
        end
    end

    // Zero-latency read mux; write-only and unused bits read as 0.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0: bus.readdata = 32'(data_q);
            3'd1: bus.readdata = 32'(mode_q);
            3'd2: bus.readdata = 32'(period_q);
            3'd3: bus.readdata = 32'(duty_q);
            3'd7: bus.readdata = {30'd0, pwm_on_c, phase_q};
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_hps_fgpa_led_pwm_output.sv
// Scoreboard bench for the LED PWM output port: out_port expectations are
// queued with their due cycle when stimulus is driven and popped by a monitor.
module tb_hps_fgpa_led_pwm_output;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] out_port;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         r = 0;

    typedef struct {
        int         due;
        logic [3:0] exp;
        string      tag;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    hps_fgpa_led_pwm_output_if bus();

    hps_fgpa_led_pwm_output #(
        .WIDTH(4), .PERIOD_W(24), .DEFAULT_PERIOD(12500000),
        .PWM_W(8), .RESET_VALUE(4'h5)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .out_port(out_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sb_push(input string tag, input logic [3:0] v, input int due);
        sb_t e;
        e.due = due;
        e.exp = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: pop expectations whose due cycle has arrived.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.due < cyc)
                check({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.due));
            else
                check(mon_e.tag, 32'(out_port), 32'(mon_e.exp));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic wr_exp(input logic [2:0] a, input logic [31:0] d,
                          input string tag, input logic [3:0] exp);
        int t;
        t = cyc;
        wr(a, d);
        sb_push(tag, exp, t + 2);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        check("rst_out0", 32'(out_port), 32'h0);
        reset = 1'b0;
        r = cyc;
        sb_push("rst_out_rv", 4'h5, cyc + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int k0;
        int k1;
        int c;
        bit ph;
        bit on;

        bus.address    = '0;
        bus.writedata  = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        // Reset values
        do_reset(3);
        rd(3'd2, 32'd12500000, "rst_period");
        rd(3'd3, 32'd256, "rst_duty");
        rd(3'd0, 32'h5, "rst_data");
        rd(3'd1, 32'h0, "rst_mode");
        rd(3'd7, 32'h3, "rst_status");
        tick();
        tick();

        // Atomic DATA operations
        wr_exp(3'd0, 32'hA, "out_data_a", 4'hA);
        rd(3'd0, 32'hA, "rd_data_a");
        wr_exp(3'd4, 32'hFFFF_FFF1, "out_set", 4'hB);
        rd(3'd0, 32'hB, "rd_set");
        wr_exp(3'd5, 32'h8, "out_clr", 4'h3);
        rd(3'd0, 32'h3, "rd_clr");
        wr_exp(3'd6, 32'h6, "out_tgl", 4'h5);
        rd(3'd0, 32'h5, "rd_tgl");
        rd(3'd4, 32'h0, "rd_outset");
        tick();
        tick();

        // Blink with PERIOD=3 on channel 0
        k0 = cyc;
        wr(3'd2, 32'd3);
        wr(3'd1, 32'h1);
        wr(3'd0, 32'hF);
        rd(3'd2, 32'd3, "rd_period3");
        for (int i = 0; i < 20; i++) begin
            c  = cyc;
            ph = (((c - k0 - 1) / 4) % 2) == 0;
            sb_push("blink4", {3'b111, ph}, c + 1);
            rd(3'd7, {30'd0, 1'b1, ph}, "status_blink4");
            tick();
        end

        // PERIOD=0: toggle every clock
        k0 = cyc;
        wr(3'd2, 32'd0);
        wr(3'd1, 32'hF);
        for (int i = 0; i < 10; i++) begin
            c  = cyc;
            ph = ((c - k0 - 1) % 2) == 0;
            sb_push("blink1", ph ? 4'hF : 4'h0, c + 1);
            tick();
        end

        // PERIOD=5 written mid-run: phase restarts at 1, toggles after 6 clocks
        k1 = cyc;
        wr(3'd2, 32'd5);
        for (int i = 0; i < 14; i++) begin
            c  = cyc;
            ph = (((c - k1 - 1) / 6) % 2) == 0;
            sb_push("blink6", ph ? 4'hF : 4'h0, c + 1);
            rd(3'd7, {30'd0, 1'b1, ph}, "status_blink6");
            tick();
        end

        // PWM with DUTY=64 over more than one PWM period
        wr(3'd2, 32'd1000000);
        wr(3'd1, 32'h0);
        wr(3'd3, 32'd64);
        for (int i = 0; i < 300; i++) begin
            c  = cyc;
            on = ((c - r) % 256) < 64;
            sb_push("pwm64", on ? 4'hF : 4'h0, c + 1);
            if (i % 16 == 0)
                rd(3'd7, {30'd0, on, 1'b1}, "status_pwm64");
            tick();
        end

        // DUTY=0: always off
        wr(3'd3, 32'd0);
        rd(3'd3, 32'd0, "rd_duty0");
        for (int i = 0; i < 20; i++) begin
            sb_push("pwm0", 4'h0, cyc + 1);
            tick();
        end

        // DUTY=300 (above full scale): always on
        wr(3'd3, 32'd300);
        rd(3'd3, 32'd300, "rd_duty300");
        for (int i = 0; i < 20; i++) begin
            sb_push("pwm300", 4'hF, cyc + 1);
            tick();
        end

        // Reset in the middle of blink + PWM
        wr(3'd3, 32'd64);
        wr(3'd1, 32'hF);
        wr(3'd2, 32'd3);
        repeat (13) tick();
        do_reset(1);
        rd(3'd2, 32'd12500000, "rst2_period");
        rd(3'd3, 32'd256, "rst2_duty");
        rd(3'd0, 32'h5, "rst2_data");
        rd(3'd1, 32'h0, "rst2_mode");
        rd(3'd7, 32'h3, "rst2_status");
        tick();

        // Write to STATUS and reads of write-only addresses have no effect
        wr_exp(3'd7, 32'hFFFF_FFFF, "out_wr7", 4'h5);
        rd(3'd0, 32'h5, "wr7_data");
        rd(3'd1, 32'h0, "wr7_mode");
        rd(3'd2, 32'd12500000, "wr7_period");
        rd(3'd3, 32'd256, "wr7_duty");
        rd(3'd4, 32'h0, "rd_addr4");
        rd(3'd5, 32'h0, "rd_addr5");
        rd(3'd6, 32'h0, "rd_addr6");
        rd(3'd0, 32'h5, "rd4_data");
        for (int i = 0; i < 4; i++) begin
            sb_push("out_hold", 4'h5, cyc + 1);
            tick();
        end

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() != 0)
            check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
